// File: rtl/wave_mixer_if.sv
// Mixer bus: per-strobe channel samples, mute/volume control, and the mixed
// result with its status flags. The master drives stimulus; the mixer is the slave.
interface wave_mixer_if;
    logic         sample_stb;
    logic [127:0] chan_snd;
    logic [7:0]   mute;
    logic         vol_we;
    logic [2:0]   vol_chan;
    logic [7:0]   vol_data;
    logic         ovr_clr;
    logic [15:0]  mix_snd;
    logic         mix_valid;
    logic         mix_clip;
    logic         busy;
    logic         ovr;

    modport master (
        output sample_stb, chan_snd, mute, vol_we, vol_chan, vol_data, ovr_clr,
        input  mix_snd, mix_valid, mix_clip, busy, ovr
    );

    modport slave (
        input  sample_stb, chan_snd, mute, vol_we, vol_chan, vol_data, ovr_clr,
        output mix_snd, mix_valid, mix_clip, busy, ovr
    );
endinterface

// File: rtl/wave_mixer.sv
// Eight-channel PCM mixer: snapshots all channels on a strobe, accumulates one
// volume-scaled channel per clock, then emits one saturated 16-bit sample.
module wave_mixer (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    wave_mixer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [2:0]         ch_reg, ch_next;
    logic signed [27:0] acc_reg, acc_next;
    logic [7:0]         mask_reg;
    logic [15:0]        snd_reg;
    logic               valid_reg, clip_reg, ovr_reg, ovr_next;

    logic [15:0]        snap_w [8];
    logic [7:0]         vol_w  [8];
    logic               start;

    assign start = (state_reg == ST_IDLE) && bus.sample_stb;

    // Per-channel snapshot and volume registers; each lane owns its own flops.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chan
            logic [15:0] snap_reg;
            logic [7:0]  vol_reg;

            always_ff @(posedge I_CLK or negedge I_RSTn) begin
                if (!I_RSTn) begin
                    snap_reg <= '0;
                    vol_reg  <= 8'd16;
                end else begin
                    if (start)
                        snap_reg <= bus.chan_snd[16*gi +: 16];
                    if (bus.vol_we && (bus.vol_chan == 3'(gi)))
                        vol_reg <= bus.vol_data;
                end
            end

            assign snap_w[gi] = snap_reg;
            assign vol_w[gi]  = vol_reg;
        end
    endgenerate

    logic signed [15:0] cur_snap;
    logic [7:0]         cur_vol;
    logic signed [24:0] prod, term;

    assign cur_snap = snap_w[ch_reg];
    assign cur_vol  = vol_w[ch_reg];
    assign prod     = 25'(cur_snap) * 25'($signed({1'b0, cur_vol}));
    assign term     = mask_reg[ch_reg] ? 25'sd0 : prod;

    // Dropping the low 7 bits of a signed value is a floor divide by 128.
    logic signed [20:0] acc_shr;
    logic [15:0]        sat_snd;
    logic               sat_clip;

    assign acc_shr = acc_reg[27:7];

    always_comb begin
        sat_snd  = acc_shr[15:0];
        sat_clip = 1'b0;
        if (acc_shr > 21'sd32767) begin
            sat_snd  = 16'h7FFF;
            sat_clip = 1'b1;
        end else if (acc_shr < -21'sd32768) begin
            sat_snd  = 16'h8000;
            sat_clip = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        acc_next   = acc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.sample_stb) begin
                    acc_next   = '0;
                    ch_next    = 3'd0;
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_next = acc_reg + 28'(term);
                ch_next  = ch_reg + 3'd1;
                if (ch_reg == 3'd7)
                    state_next = ST_OUT;
            end
            ST_OUT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A strobe that arrives mid-pass is dropped but remembered; set beats clear.
    always_comb begin
        ovr_next = ovr_reg;
        if (bus.sample_stb && (state_reg != ST_IDLE))
            ovr_next = 1'b1;
        else if (bus.ovr_clr)
            ovr_next = 1'b0;
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_reg <= ST_IDLE;
            ch_reg    <= '0;
            acc_reg   <= '0;
            mask_reg  <= '0;
            snd_reg   <= '0;
            valid_reg <= 1'b0;
            clip_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            acc_reg   <= acc_next;
            ovr_reg   <= ovr_next;
            if (start)
                mask_reg <= bus.mute;
            valid_reg <= (state_reg == ST_OUT);
            clip_reg  <= (state_reg == ST_OUT) && sat_clip;
            if (state_reg == ST_OUT)
                snd_reg <= sat_snd;
        end
    end

    assign bus.mix_snd   = snd_reg;
    assign bus.mix_valid = valid_reg;
    assign bus.mix_clip  = clip_reg;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.ovr       = ovr_reg;
endmodule

// File: tb/tb_wave_mixer.sv
// Scoreboard bench for wave_mixer: stimulus pushes model results, a monitor
// pops and compares them whenever the mixer pulses its valid output.
`timescale 1ns/1ps
module tb_wave_mixer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wave_mixer_if bus ();
    wave_mixer dut (.I_CLK(clk), .I_RSTn(rstn), .bus(bus));

    typedef struct packed {
        logic [15:0] snd;
        logic        clip;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   model_vol[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: weighted sum, floor-divide by 128, clamp to 16-bit range.
    function automatic exp_t model(input int s[8], input logic [7:0] m, input int v[8], input int e);
        int   sum;
        int   r;
        exp_t x;
        sum = 0;
        for (int c = 0; c < 8; c++)
            if (!m[c]) sum += s[c] * v[c];
        r = sum / 128;
        if ((sum % 128 != 0) && (sum < 0)) r = r - 1;
        x.clip = 1'b0;
        if (r > 32767)       begin r = 32767;  x.clip = 1'b1; end
        else if (r < -32768) begin r = -32768; x.clip = 1'b1; end
        x.snd     = r[15:0];
        x.edge_no = e;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (bus.mix_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                x = exp_q.pop_front();
                $display("mix: snd=%0d clip=%0d cycle=%0d", $signed(bus.mix_snd), bus.mix_clip, cyc);
                chk("mix_snd", int'($signed(bus.mix_snd)), int'($signed(x.snd)));
                chk("mix_clip", int'(bus.mix_clip), int'(x.clip));
                chk("valid_edge", cyc, x.edge_no);
            end
        end
    end

    task automatic drive_snd(input int s[8]);
        for (int i = 0; i < 8; i++) bus.chan_snd[16*i +: 16] = s[i][15:0];
    endtask

    task automatic vol_write(input int c, input int v);
        bus.vol_we   = 1'b1;
        bus.vol_chan = c[2:0];
        bus.vol_data = v[7:0];
        @(negedge clk);
        bus.vol_we = 1'b0;
        model_vol[c] = v;
    endtask

    // One pass: strobe lands on edge k; mid-pass actions at offset w land on edge k+w.
    // Returns on the negedge after edge k+9, so the next call strobes at k+10.
    task automatic run_pass(input int s[8], input logic [7:0] m, input int wr_w, input int wr_c,
                            input int wr_v, input int snd_w, input int stb2_w, input int clr_w);
        int v_eff[8];
        int busy_n;
        busy_n = 0;
        v_eff  = model_vol;
        if (wr_w != 0 && wr_c >= wr_w) v_eff[wr_c] = wr_v;
        drive_snd(s);
        bus.mute       = m;
        bus.sample_stb = 1'b1;
        exp_q.push_back(model(s, m, v_eff, cyc + 10));
        for (int w = 1; w <= 10; w++) begin
            @(negedge clk);
            bus.sample_stb = 1'b0;
            bus.vol_we     = 1'b0;
            bus.ovr_clr    = 1'b0;
            if (bus.busy) busy_n++;
            if (w == wr_w) begin
                bus.vol_we   = 1'b1;
                bus.vol_chan = wr_c[2:0];
                bus.vol_data = wr_v[7:0];
            end
            if (w == snd_w) begin
                bus.chan_snd = {$urandom, $urandom, $urandom, $urandom};
                bus.mute     = ~m;
            end
            if (w == stb2_w) bus.sample_stb = 1'b1;
            if (w == clr_w)  bus.ovr_clr = 1'b1;
        end
        if (wr_w != 0) model_vol[wr_c] = wr_v;
        chk("busy_cycles", busy_n, 9);
    endtask

    task automatic clear_ovr();
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        chk("ovr_cleared", int'(bus.ovr), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s[8];
        int rc, rv;
        bus.sample_stb = 1'b0;
        bus.chan_snd   = '0;
        bus.mute       = '0;
        bus.vol_we     = 1'b0;
        bus.vol_chan   = '0;
        bus.vol_data   = '0;
        bus.ovr_clr    = 1'b0;
        for (int c = 0; c < 8; c++) model_vol[c] = 16;

        repeat (3) @(negedge clk);
        chk("rst_snd",   int'(bus.mix_snd), 0);
        chk("rst_valid", int'(bus.mix_valid), 0);
        chk("rst_clip",  int'(bus.mix_clip), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_ovr",   int'(bus.ovr), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Default 1/8 gain: full-scale on every channel must not clip.
        for (int c = 0; c < 8; c++) s[c] = 32767;
        run_pass(s, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) s[c] = -32768;
        run_pass(s, 8'h00, 0, 0, 0, 0, 0, 0);

        vol_write(0, 128);
        s = '{1000, 0, 0, 0, 0, 0, 0, 0};
        run_pass(s, 8'hFE, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 8; c++) vol_write(c, 255);
        for (int c = 0; c < 8; c++) s[c] = 32767;
        run_pass(s, 8'h00, 0, 0, 0, 0, 0, 0);
        s = '{-32768, 0, 0, 0, 0, 0, 0, 0};
        run_pass(s, 8'hFE, 0, 0, 0, 0, 0, 0);

        vol_write(0, 1);
        s = '{-1, 0, 0, 0, 0, 0, 0, 0};
        run_pass(s, 8'hFE, 0, 0, 0, 0, 0, 0);
        s = '{1, 0, 0, 0, 0, 0, 0, 0};
        run_pass(s, 8'hFE, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 8; c++) vol_write(c, 100);
        s = '{3000, -2000, 500, 7000, -9000, 1200, 400, -30};
        run_pass(s, 8'h00, 0, 0, 0, 0, 4, 0);
        chk("ovr_set_k4", int'(bus.ovr), 1);
        clear_ovr();
        run_pass(s, 8'h21, 0, 0, 0, 0, 9, 0);
        chk("ovr_set_k9", int'(bus.ovr), 1);
        run_pass(s, 8'h00, 0, 0, 0, 0, 0, 0);
        clear_ovr();
        run_pass(s, 8'h00, 0, 0, 0, 0, 5, 5);
        chk("ovr_set_wins", int'(bus.ovr), 1);
        clear_ovr();

        run_pass(s, 8'h00, 0, 0, 0, 3, 0, 0);
        run_pass(s, 8'h00, 2, 7, 200, 0, 0, 0);
        drain();

        // Reset mid-pass: pass is abandoned, no valid may follow.
        s = '{20000, 20000, 20000, 20000, 0, 0, 0, 0};
        drive_snd(s);
        bus.mute       = 8'h00;
        bus.sample_stb = 1'b1;
        @(negedge clk);
        bus.sample_stb = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_snd",   int'(bus.mix_snd), 0);
        chk("abort_valid", int'(bus.mix_valid), 0);
        chk("abort_clip",  int'(bus.mix_clip), 0);
        chk("abort_busy",  int'(bus.busy), 0);
        chk("abort_ovr",   int'(bus.ovr), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) model_vol[c] = 16;
        repeat (12) @(negedge clk);
        run_pass(s, 8'h00, 0, 0, 0, 0, 0, 0);

        for (int p = 0; p < 40; p++) begin
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                rc = int'($urandom_range(0, 7));
                rv = int'($urandom_range(0, 255));
                vol_write(rc, rv);
            end
            for (int c = 0; c < 8; c++) begin
                case ($urandom_range(0, 3))
                    0:       s[c] = 32767;
                    1:       s[c] = -32768;
                    default: s[c] = int'($urandom_range(0, 65535)) - 32768;
                endcase
            end
            rc = int'($urandom_range(0, 7));
            rv = int'($urandom_range(0, 255));
            run_pass(s, 8'($urandom), int'($urandom_range(0, 9)), rc, rv,
                     int'($urandom_range(0, 9)), 0, 0);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/wave_mixer.md
# wave_mixer

Eight-channel PCM mixer that sits directly downstream of the per-channel `wave_sound` sample players and feeds the audio output path. On each output-rate strobe it snapshots all eight signed 16-bit channel samples. It then scales each one by a per-channel 8-bit volume, accumulating one channel per clock, and emits one saturated signed 16-bit mixed sample with a one-cycle valid pulse.

## Interface
- No parameters; channel count fixed at 8, volume width fixed at 8.
- I_CLK  in  1  system clock
- I_RSTn  in  1  reset; asynchronous, active-low; clock I_CLK
- I_SAMPLE_STB  in  1  output-rate tick, one-cycle pulse; starts a mix pass
- I_SND  in  128  channel samples, signed 16 each; ch n = bits [16n+15:16n]
- I_MUTE  in  8  per-channel mute mask, 1 = channel contributes 0
- I_VOL_WE  in  1  volume register write enable
- I_VOL_CHAN  in  3  channel index for the volume write
- I_VOL_DATA  in  8  unsigned volume; 128 = unity, 255 ≈ 1.99×
- I_OVR_CLR  in  1  clears O_OVR
- O_SND  out  16  signed mixed sample, held between passes
- O_VALID  out  1  one-cycle pulse when O_SND updates
- O_CLIP  out  1  high with O_VALID when the result saturated
- O_BUSY  out  1  high in ACC and OUT states
- O_OVR  out  1  sticky flag: a strobe arrived while busy

## Operation
- States: IDLE, ACC, OUT. Reset enters IDLE.
- IDLE: when I_SAMPLE_STB=1, capture I_SND into an 8×16 snapshot and I_MUTE into a mask register. Clear the accumulator, set ch=0, go to ACC.
- ACC, each clock:
  - acc += mute[ch] ? 0 : snap[ch] × {1'b0, vol[ch]}, a signed 16×9 product of 25 bits.
  - ch increments. After ch=7 the state goes to OUT.
- Accumulator is signed 28 bits, wide enough that 8 products cannot overflow.
- OUT: r = acc >>> 7 (arithmetic shift, floor rounding), then saturate to [-32768, 32767].
  - O_SND <= saturated r; O_VALID <= 1; O_CLIP <= (r out of range).
  - Return to IDLE.
- Volume registers vol[0..7] reset to 16, which is 1/8 gain, so 8 full-scale channels cannot clip.
- A write (I_VOL_WE) updates vol[I_VOL_CHAN] at the clock edge and is legal in any state. The accumulate step reads vol[ch] at the edge it uses it, so a write to a channel not yet accumulated affects the current pass.
- I_SAMPLE_STB seen in ACC or OUT: ignored for mixing, sets O_OVR. I_OVR_CLR clears O_OVR; if both occur in the same cycle, the set wins.
- I_SND and I_MUTE are only sampled in IDLE on a strobe. Changes during a pass have no effect.

## Timing
- Reset values:
  - O_SND=0, O_VALID=0, O_CLIP=0, O_BUSY=0, O_OVR=0.
  - acc=0, ch=0, snapshot=0, mask=0, vol[*]=16.
- Reset asserted mid-pass aborts the pass immediately. No O_VALID follows.
- Strobe sampled at edge k (in IDLE) → accumulation at edges k+1..k+8 → O_SND/O_VALID/O_CLIP registered at edge k+9. O_VALID is high for exactly the cycle after edge k+9.
- O_BUSY is high from edge k to edge k+9; it is low again after edge k+9.
- A strobe at edge k+9 (state OUT) is an overrun. The earliest accepted next strobe is at edge k+10. Minimum strobe spacing is therefore 10 clocks; the audio rate (≤48 kHz at 24 MHz) is far above that bound.
- O_CLIP and O_VALID are both registered and deassert together on the cycle after the pulse.
- O_SND holds its value until the next OUT.

## Test plan
- Unity pass: vol[0]=128, I_MUTE=0xFE, ch0=1000, others 0; strobe at edge k → O_SND=1000, O_VALID=1 only after edge k+9, O_CLIP=0, O_BUSY high for 9 cycles.
- Reset defaults: no volume writes, all channels 32767, I_MUTE=0 → O_SND=32767 (8·32767·16>>>7 exact), O_CLIP=0. Same with all channels -32768 → O_SND=-32768, O_CLIP=0.
- Saturation:
  - All vol=255, all channels 32767 → O_SND=32767, O_CLIP=1.
  - ch0=-32768, vol 255, others muted → O_SND=-32768, O_CLIP=1.
- Floor rounding: ch0=-1, vol[0]=1, others muted → O_SND=-1. Then ch0=+1 → O_SND=0.
- Overrun:
  - Second strobe at k+4 → O_OVR=1, the result at k+9 is unchanged, no second O_VALID.
  - Strobe at k+10 → accepted.
  - I_OVR_CLR with no coincident strobe → O_OVR=0.
- Mid-pass events:
  - Change I_SND at k+3 → output still reflects the snapshot.
  - Write vol[7] at k+2 → new value used.
  - Assert I_RSTn low at k+5 → all outputs at reset values, no O_VALID; a fresh strobe afterwards mixes normally.
